adc_sample_conditioner: RTL and testbench
=========================================

ADC_SAMPLE_CONDITIONER -- requirements
Module: adc_sample_conditioner

Interface
REQ-001 SHALL have parameter WDTH, default 18, width of the raw sigma_delta_adc output word.
REQ-002 SHALL have parameter OUT_W, default 16, width of the signed output sample; WDTH-2 >= OUT_W required.
REQ-003 SHALL have parameter DEPTH, default 8, sample FIFO depth, power of two, >= 2.
REQ-004 SHALL have parameter DCB_K, default 10, DC-blocker pole shift (used only with ADC_COND_DCBLOCK_EN).
REQ-005 clk  input  1  sole clock, shared with sigma_delta_adc.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 adc_output  input  WDTH  unsigned decimated sample from sigma_delta_adc.
REQ-008 adc_valid  input  1  one-cycle strobe qualifying adc_output.
REQ-009 out_data  output  OUT_W  signed two's-complement conditioned sample.
REQ-010 out_valid  output  1  out_data holds a valid sample.
REQ-011 out_ready  input  1  consumer accepts; transfer when out_valid and out_ready both high.
REQ-012 drop_cnt  output  8  saturating count of samples dropped on FIFO full.
REQ-013 sat_flag  output  1  sticky: at least one sample saturated.

Function
REQ-014 Full-scale code F = 2^(WDTH-2); an input of all ones (2^WDTH-1, decimator wrap artifact) SHALL be replaced by F/2 before conversion.
REQ-015 Conversion SHALL compute s = x - F/2 in WDTH+1 signed bits, then arithmetic shift right by WDTH-2-OUT_W.
REQ-016 Result SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clipped sample sets sat_flag.
REQ-017 Conversion SHALL be one registered stage: adc_valid at cycle N yields FIFO write at end of cycle N+1.
REQ-018 With FIFO empty and out_ready high, out_valid SHALL assert in cycle N+2 (latency 2 without DC blocker).
REQ-019 FIFO SHALL be first-word-fall-through, registered out_data/out_valid, read/write pointers log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-020 Write when full and no simultaneous pop: sample dropped, FIFO contents unchanged, drop_cnt += 1 saturating at 255.
REQ-021 Write when full with simultaneous pop in same cycle: pop and write both SHALL complete, no drop.
REQ-022 Write and pop on empty FIFO in same cycle: pop ignored (out_valid low), write stored.
REQ-023 Sample order SHALL be preserved; no sample duplicated or reordered.
REQ-024 out_data SHALL stay stable while out_valid high and out_ready low.
REQ-025 adc_valid asserted on consecutive cycles SHALL be accepted each cycle (throughput one sample/clock).

Reset
REQ-026 On rst high at a clk edge: FIFO emptied, out_valid=0, out_data=0, drop_cnt=0, sat_flag=0, conversion stage valid cleared, DC-blocker state zeroed.
REQ-027 Reset mid-operation SHALL discard all buffered and in-flight samples; adc_valid during reset ignored.
REQ-028 First sample accepted SHALL be one with adc_valid high in the first cycle rst is low.

Configuration
REQ-029 Macro ADC_COND_DCBLOCK_EN defined: a DC blocker y[n] = s[n] - s[n-1] + y[n-1] - (y[n-1] >>> DCB_K), OUT_W+DCB_K+2 bit internal state, SHALL follow conversion, before saturation, adding one cycle (latency 3); state updates only on valid samples.
REQ-030 Macro undefined: no DC-blocker logic, latency 2, DCB_K unused.

Verification (WDTH=18, OUT_W=16, DEPTH=8, macro undefined unless stated)
REQ-031 adc_output=32768 -> out_data=0; 0 -> -32768; 65536 -> 32767 and sat_flag=1; 262143 -> 0, sat_flag unchanged.
REQ-032 out_ready=0, 10 consecutive adc_valid strobes -> 8 samples held, drop_cnt=2; then out_ready=1 -> first 8 samples out in order, one per cycle.
REQ-033 FIFO full, out_ready=1 and adc_valid in same cycle -> no drop, drop_cnt unchanged, new sample emerges last.
REQ-034 Single adc_valid at cycle N, empty FIFO -> out_valid first high in cycle N+2; held with out_ready=0 -> out_data stable.
REQ-035 rst pulsed with 5 samples buffered and drop_cnt=3 -> next cycle out_valid=0, drop_cnt=0, sat_flag=0; next sample is first out.
REQ-036 Macro defined, constant adc_output=40000 for 20000 samples -> first out_data=7232, magnitude decays monotonically to |out_data| <= 1.

Source files
------------

// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: turns the unsigned sigma-delta decimator word into a
// signed, saturated sample and buffers it in a first-word-fall-through FIFO.
// Optional feature macro: ADC_COND_DCBLOCK_EN inserts a one-pole DC blocker
// between conversion and saturation, adding one cycle of latency.
//
// Handshake: a sample transfers on any clk edge where out_valid and out_ready
// are both high; out_data is held stable while out_valid is high and out_ready
// is low. adc_valid is a one-cycle strobe with no back-pressure, so samples
// that arrive while the FIFO is full (and nothing pops) are counted and dropped.
module adc_sample_conditioner #(
  parameter int WDTH  = 18,
  parameter int OUT_W = 16,
  parameter int DEPTH = 8,
  parameter int DCB_K = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WDTH-1:0]         adc_output,
  input  logic                    adc_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              drop_cnt,
  output logic                    sat_flag
);
  localparam int SW = WDTH + 1;         // signed width of the offset-removed sample
  localparam int SH = WDTH - 2 - OUT_W; // shift from full-scale code to OUT_W
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;           // one extra bit separates full from empty
  localparam logic [WDTH-1:0] HALF = WDTH'(2 ** (WDTH - 3));

  if ((WDTH - 2 < OUT_W) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DCB_K < 1)) begin : g_bad_params
    $error("adc_sample_conditioner: illegal parameter combination");
  end

  // Remove the mid-scale offset; the all-ones wrap artifact maps to mid-scale.
  logic [WDTH-1:0]      x_fix;
  logic signed [SW-1:0] s_full;
  logic signed [SW-1:0] s_conv;
  always_comb begin
    x_fix  = (&adc_output) ? HALF : adc_output;
    s_full = $signed({1'b0, x_fix}) - $signed({1'b0, HALF});
    s_conv = s_full >>> SH;
  end

`ifdef ADC_COND_DCBLOCK_EN
  localparam int PRE_W = OUT_W + DCB_K + 2;
`else
  localparam int PRE_W = SW;
`endif
  localparam logic signed [PRE_W-1:0] PRE_MAX = PRE_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PRE_W-1:0] PRE_MIN = PRE_W'(-(2 ** (OUT_W - 1)));

  logic signed [PRE_W-1:0] pre;
  logic signed [OUT_W-1:0] sat_val;
  logic                    clip;
  logic                    sat_set;
  logic                    push;
  logic signed [OUT_W-1:0] push_data;

  // Clamp the pre-saturation value into the OUT_W signed range.
  always_comb begin
    clip    = 1'b0;
    sat_val = pre[OUT_W-1:0];
    if (pre > PRE_MAX) begin
      clip    = 1'b1;
      sat_val = PRE_MAX[OUT_W-1:0];
    end else if (pre < PRE_MIN) begin
      clip    = 1'b1;
      sat_val = PRE_MIN[OUT_W-1:0];
    end
  end

`ifdef ADC_COND_DCBLOCK_EN
  // y is kept with DCB_K fractional bits so the leak term keeps decaying
  // the output all the way down to the last LSB.
  logic                    s_valid;
  logic signed [SW-1:0]    s_q;
  logic signed [SW-1:0]    s_prev;
  logic signed [PRE_W-1:0] y_q;
  logic signed [PRE_W-1:0] y_next;
  logic signed [PRE_W-1:0] diff;
  logic                    dc_valid;
  logic signed [OUT_W-1:0] dc_data;

  // Conversion stage: register the offset-removed sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_q     <= '0;
    end else begin
      s_valid <= adc_valid;
      if (adc_valid) s_q <= s_conv;
    end
  end

  // Blocker recurrence evaluated on the registered sample.
  always_comb begin
    diff   = PRE_W'(s_q) - PRE_W'(s_prev);
    y_next = (diff <<< DCB_K) + y_q - (y_q >>> DCB_K);
    pre    = y_next >>> DCB_K;
  end

  assign sat_set = s_valid & clip;

  // Blocker stage: state advances only on valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_valid <= 1'b0;
      dc_data  <= '0;
      y_q      <= '0;
      s_prev   <= '0;
    end else begin
      dc_valid <= s_valid;
      if (s_valid) begin
        y_q     <= y_next;
        s_prev  <= s_q;
        dc_data <= sat_val;
      end
    end
  end

  assign push      = dc_valid;
  assign push_data = dc_data;
`else
  logic                    conv_valid;
  logic signed [OUT_W-1:0] conv_data;

  assign pre     = s_conv;
  assign sat_set = adc_valid & clip;

  // Conversion stage: register the saturated sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_valid <= 1'b0;
      conv_data  <= '0;
    end else begin
      conv_valid <= adc_valid;
      if (adc_valid) conv_data <= sat_val;
    end
  end

  assign push      = conv_valid;
  assign push_data = conv_data;
`endif

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next, count;
  logic          full, pop, do_write, drop;

  // FIFO control: a pop frees the slot a same-cycle write into a full FIFO needs.
  always_comb begin
    count    = wr_ptr - rd_ptr;
    full     = (count == PW'(DEPTH));
    pop      = out_valid & out_ready;
    do_write = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_next  = wr_ptr + PW'(do_write);
    rd_next  = rd_ptr + PW'(pop);
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers, registered head-of-queue output and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      drop_cnt  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      out_valid <= (wr_next != rd_next);
      // A write landing at the next head slot bypasses the memory.
      if (do_write && (wr_ptr == rd_next)) out_data <= push_data;
      else                                 out_data <= mem[rd_next[AW-1:0]];
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (sat_set) sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed testbench for adc_sample_conditioner (WDTH=18, OUT_W=16, DEPTH=8).
// Define ADC_COND_DCBLOCK_EN to build the DC-blocker variant and its test.
module tb_adc_sample_conditioner;
  logic               clk;
  logic               rst;
  logic [17:0]        adc_output;
  logic               adc_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         drop_cnt;
  logic               sat_flag;

  int checks;
  int failures;
  logic [15:0] exp_q[$];

  adc_sample_conditioner #(
    .WDTH(18), .OUT_W(16), .DEPTH(8), .DCB_K(10)
  ) dut (
    .clk(clk), .rst(rst), .adc_output(adc_output), .adc_valid(adc_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .sat_flag(sat_flag)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 ns after the active edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    adc_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    adc_valid = 1'b1;
    adc_output = 18'd40000;
    out_ready = 1'b1;
    tick;
    tick;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 16'sd0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
    rst = 1'b0;
    adc_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ignores_valid: got %b expected 0", out_valid); end
  endtask

`ifdef ADC_COND_DCBLOCK_EN
  task automatic test_dcblock;
    int prev_mag;
    int mag;
    do_reset;
    out_ready = 1'b1;
    adc_output = 18'd40000;
    adc_valid = 1'b1;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL dc_latency_early: got %b expected 0", out_valid); end
    tick;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL dc_latency: got %b expected 1", out_valid); end
    if (out_data !== 16'sd7232) begin failures++; $display("FAIL dc_first: got %0d expected 7232", out_data); end
    prev_mag = 7232;
    for (int i = 0; i < 19997; i++) begin
      tick;
      mag = (out_data < 0) ? -int'(out_data) : int'(out_data);
      checks++;
      if (mag > prev_mag) begin
        failures++;
        $display("FAIL dc_monotonic: got %0d expected <= %0d at step %0d", mag, prev_mag, i);
      end
      prev_mag = mag;
    end
    adc_valid = 1'b0;
    checks += 2;
    if (prev_mag > 1) begin failures++; $display("FAIL dc_final: got %0d expected <= 1", prev_mag); end
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL dc_sat: got %b expected 0", sat_flag); end
  endtask
`else
  task automatic test_conversion;
    int xin   [6] = '{32768, 0, 65536, 262143, 40000, 1};
    int exp_d [6] = '{0, -32768, 32767, 0, 7232, -32767};
    int exp_s [6] = '{0, 0, 1, 1, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      adc_output = 18'(xin[i]);
      adc_valid = 1'b1;
      tick;
      adc_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL conv_early[%0d]: got %b expected 0", i, out_valid); end
      tick;
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL conv_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== 16'(exp_d[i])) begin failures++; $display("FAIL conv_data[%0d]: got %0d expected %0d", i, out_data, exp_d[i]); end
      if (sat_flag !== 1'(exp_s[i])) begin failures++; $display("FAIL conv_sat[%0d]: got %b expected %0d", i, sat_flag, exp_s[i]); end
      tick;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL conv_drain[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    adc_output = 18'd50000;
    adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_early: got %b expected 0", out_valid); end
    tick;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_latency: got %b expected 1", out_valid); end
    if (out_data !== 16'sd17232) begin failures++; $display("FAIL hold_data: got %0d expected 17232", out_data); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid_stable[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== 16'sd17232) begin failures++; $display("FAIL hold_data_stable[%0d]: got %0d expected 17232", i, out_data); end
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_pop: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow;
    logic [15:0] exp;
    do_reset;
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      adc_output = 18'(32768 + 100 * i);
      adc_valid = 1'b1;
      if (i < 8) exp_q.push_back(16'(100 * i));
      tick;
    end
    adc_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp = exp_q.pop_front();
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid[%0d]: got %b expected 1", j, out_valid); end
      if (out_data !== exp) begin failures++; $display("FAIL ovf_data[%0d]: got %0d expected %0d", j, out_data, $signed(exp)); end
      tick;
    end
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty: got %b expected 0", out_valid); end
    if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_hold: got %0d expected 2", drop_cnt); end
  endtask

  task automatic test_full_pop_write;
    logic [15:0] exp;
    do_reset;
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      adc_output = 18'(32768 + 10 * i);
      adc_valid = 1'b1;
      exp_q.push_back(16'(10 * i));
      tick;
    end
    adc_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL fpw_no_drop_fill: got %0d expected 0", drop_cnt); end
    adc_output = 18'(32768 + 999);
    adc_valid = 1'b1;
    exp_q.push_back(16'd999);
    tick;
    adc_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      exp = exp_q.pop_front();
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL fpw_valid[%0d]: got %b expected 1", j, out_valid); end
      if (out_data !== exp) begin failures++; $display("FAIL fpw_data[%0d]: got %0d expected %0d", j, out_data, $signed(exp)); end
      tick;
    end
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fpw_empty: got %b expected 0", out_valid); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL fpw_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_back_to_back;
    int exp;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      adc_valid = (c < 6);
      adc_output = 18'(32768 - 500 * c);
      checks++;
      if (c >= 2 && c < 8) begin
        exp = -500 * (c - 2);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c, out_valid); end
        if (out_data !== 16'(exp)) begin failures++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", c, out_data, exp); end
      end else begin
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle[%0d]: got %b expected 0", c, out_valid); end
      end
      tick;
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      adc_output = (i == 0) ? 18'd70000 : 18'(32768 + 7 * i);
      adc_valid = 1'b1;
      tick;
    end
    adc_valid = 1'b0;
    tick;
    tick;
    checks += 2;
    if (drop_cnt !== 8'd3) begin failures++; $display("FAIL mid_drop_cnt: got %0d expected 3", drop_cnt); end
    if (sat_flag !== 1'b1) begin failures++; $display("FAIL mid_sat_set: got %b expected 1", sat_flag); end
    out_ready = 1'b1;
    tick;
    tick;
    tick;
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
    if (out_data !== 16'sd21) begin failures++; $display("FAIL mid_head: got %0d expected 21", out_data); end
    adc_output = 18'd12345;
    adc_valid = 1'b1;
    tick;
    rst = 1'b1;
    adc_output = 18'd54321;
    tick;
    rst = 1'b0;
    adc_output = 18'(32768 + 4242);
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    if (out_data !== 16'sd0) begin failures++; $display("FAIL mid_rst_data: got %0d expected 0", out_data); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_drop: got %0d expected 0", drop_cnt); end
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL mid_rst_sat: got %b expected 0", sat_flag); end
    tick;
    adc_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_inflight: got %b expected 0", out_valid); end
    tick;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_first_valid: got %b expected 1", out_valid); end
    if (out_data !== 16'sd4242) begin failures++; $display("FAIL mid_first_data: got %0d expected 4242", out_data); end
    out_ready = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_only_one: got %b expected 0", out_valid); end
  endtask
`endif

  // Test sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    adc_valid = 1'b0;
    adc_output = '0;
    out_ready = 1'b0;
    test_reset;
`ifdef ADC_COND_DCBLOCK_EN
    test_dcblock;
`else
    test_conversion;
    test_hold;
    test_overflow;
    test_full_pop_write;
    test_back_to_back;
    test_reset_mid;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
